fb_blitter: RTL and testbench

- Writer-side engine for the 240x160 x 24-bit framebuffer RAM; the scan-out drawer is the reader of the same RAM.
- Copies a rectangle from a read-only source sprite/map RAM into the framebuffer at a given destination.
- Source reads have 1-cycle latency. Transparency key colour is skipped, horizontal mirror is optional per blit, and destinations are clipped.
- Driven by the game-state logic through a start/busy/done handshake, once per object per frame, during blanking.

---
 rtl/fb_pkg.sv | 16 +
 rtl/fb_blit_addr_gen.sv | 71 +++++++
 rtl/fb_blitter.sv | 148 ++++++++++++++
 tb/tb_fb_blitter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer constants and blit FSM state type; used by the blitter and the scan-out drawer.
package fb_pkg;
  localparam int FB_W   = 240;
  localparam int FB_H   = 160;
  localparam int SRC_W  = 271;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 24;
  localparam logic [PIX_W-1:0] KEY_COLOR = 24'hFF00FF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } blit_state_e;
endpackage

// File: rtl/fb_blit_addr_gen.sv
// Blit address generator: row-major col/row walk, mirrored source column, source/dest
// address multiply-add and the destination clip flag.
module fb_blit_addr_gen
  import fb_pkg::*;
#(
  parameter int SRC_PITCH = SRC_W,
  parameter int DST_W     = FB_W,
  parameter int DST_H     = FB_H
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic [8:0]        srcX_i,
  input  logic [8:0]        srcY_i,
  input  logic [8:0]        dstX_i,
  input  logic [8:0]        dstY_i,
  input  logic [5:0]        width_i,
  input  logic [5:0]        height_i,
  input  logic              mirror_i,
  output logic [ADDR_W-1:0] srcAddr_o,
  output logic [ADDR_W-1:0] dstAddr_o,
  output logic              valid_o,
  output logic              last_o
);
  logic [5:0] col_q, col_d;
  logic [5:0] row_q, row_d;
  logic [5:0] srcCol;
  logic       colEnd;
  logic [ADDR_W-1:0] srcRow, dstCol, dstRow;

  assign colEnd = (col_q == width_i - 6'd1);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (step_i) begin
      if (colEnd) begin
        col_d = '0;
        row_d = row_q + 6'd1;
      end else begin
        col_d = col_q + 6'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Mirroring only affects which source column is fetched; the destination still walks left to right.
  assign srcCol    = mirror_i ? (width_i - 6'd1 - col_q) : col_q;
  assign srcRow    = ADDR_W'(srcY_i) + ADDR_W'(row_q);
  assign srcAddr_o = srcRow * ADDR_W'(SRC_PITCH) + ADDR_W'(srcX_i) + ADDR_W'(srcCol);

  assign dstCol    = ADDR_W'(dstX_i) + ADDR_W'(col_q);
  assign dstRow    = ADDR_W'(dstY_i) + ADDR_W'(row_q);
  assign dstAddr_o = dstRow * ADDR_W'(DST_W) + dstCol;
  assign valid_o   = (dstCol < ADDR_W'(DST_W)) && (dstRow < ADDR_W'(DST_H));

  assign last_o = colEnd && (row_q == height_i - 6'd1);
endmodule

// File: rtl/fb_blitter.sv
// Framebuffer blitter: copies a source rectangle with key-colour skip, mirror and clipping.
// Define FB_BLITTER_SOLID_FILL_EN to add the fill/fill_color solid-colour mode.
module fb_blitter #(
  parameter int                   FB_W      = fb_pkg::FB_W,
  parameter int                   FB_H      = fb_pkg::FB_H,
  parameter int                   SRC_W     = fb_pkg::SRC_W,
  parameter logic [fb_pkg::PIX_W-1:0] KEY_COLOR = fb_pkg::KEY_COLOR
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       start,
  input  logic [8:0]                 src_x,
  input  logic [8:0]                 src_y,
  input  logic [8:0]                 dst_x,
  input  logic [8:0]                 dst_y,
  input  logic [5:0]                 blit_w,
  input  logic [5:0]                 blit_h,
  input  logic                       mirror,
`ifdef FB_BLITTER_SOLID_FILL_EN
  input  logic                       fill,
  input  logic [fb_pkg::PIX_W-1:0]   fill_color,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [fb_pkg::ADDR_W-1:0]  src_read_address,
  input  logic [fb_pkg::PIX_W-1:0]   src_data,
  output logic [fb_pkg::ADDR_W-1:0]  fb_write_address,
  output logic [fb_pkg::PIX_W-1:0]   fb_data_In,
  output logic                       fb_we
);
  import fb_pkg::*;

  blit_state_e state_q, state_d;
  logic        loadParams, stepPix;
  logic [8:0]  srcX_q, srcY_q, dstX_q, dstY_q;
  logic [5:0]  width_q, height_q;
  logic        mirror_q;
  logic [ADDR_W-1:0] srcAddr, dstAddr;
  logic        pixValid, lastPix;
  logic        wrValid_q, wrValid_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;

  always_comb begin
    state_d    = state_q;
    loadParams = 1'b0;
    stepPix    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          loadParams = 1'b1;
          state_d    = (blit_w == 6'd0 || blit_h == 6'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        stepPix = 1'b1;
        if (lastPix) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      wrValid_q <= 1'b0;
      wrAddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      wrValid_q <= wrValid_d;
      wrAddr_q  <= wrAddr_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      srcX_q   <= '0;
      srcY_q   <= '0;
      dstX_q   <= '0;
      dstY_q   <= '0;
      width_q  <= '0;
      height_q <= '0;
      mirror_q <= 1'b0;
    end else if (loadParams) begin
      srcX_q   <= src_x;
      srcY_q   <= src_y;
      dstX_q   <= dst_x;
      dstY_q   <= dst_y;
      width_q  <= blit_w;
      height_q <= blit_h;
      mirror_q <= mirror;
    end
  end

  fb_blit_addr_gen #(
    .SRC_PITCH(SRC_W),
    .DST_W    (FB_W),
    .DST_H    (FB_H)
  ) u_addr_gen (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear_i  (loadParams),
    .step_i   (stepPix),
    .srcX_i   (srcX_q),
    .srcY_i   (srcY_q),
    .dstX_i   (dstX_q),
    .dstY_i   (dstY_q),
    .width_i  (width_q),
    .height_i (height_q),
    .mirror_i (mirror_q),
    .srcAddr_o(srcAddr),
    .dstAddr_o(dstAddr),
    .valid_o  (pixValid),
    .last_o   (lastPix)
  );

  // Destination address and clip flag wait one cycle to line up with the source RAM data.
  assign wrValid_d = (state_q == ISSUE) && pixValid;
  assign wrAddr_d  = (state_q == ISSUE) ? dstAddr : wrAddr_q;

  assign busy             = (state_q == ISSUE) || (state_q == DRAIN);
  assign done             = (state_q == DONE);
  assign fb_write_address = wrAddr_q;

`ifdef FB_BLITTER_SOLID_FILL_EN
  logic             fill_q;
  logic [PIX_W-1:0] fillColor_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fill_q      <= 1'b0;
      fillColor_q <= '0;
    end else if (loadParams) begin
      fill_q      <= fill;
      fillColor_q <= fill_color;
    end
  end

  assign src_read_address = (state_q == ISSUE && !fill_q) ? srcAddr : '0;
  assign fb_we            = wrValid_q && (fill_q || (src_data != KEY_COLOR));
  assign fb_data_In       = wrValid_q ? (fill_q ? fillColor_q : src_data) : '0;
`else
  assign src_read_address = (state_q == ISSUE) ? srcAddr : '0;
  assign fb_we            = wrValid_q && (src_data != KEY_COLOR);
  assign fb_data_In       = wrValid_q ? src_data : '0;
`endif
endmodule

// File: tb/tb_fb_blitter.sv
// Directed bench for fb_blitter: source RAM model returns its own address as pixel data,
// except one optional key-coloured address; writes, busy and done are logged per cycle.
module tb_fb_blitter;
  import fb_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [8:0]  src_x, src_y, dst_x, dst_y;
  logic [5:0]  blit_w, blit_h;
  logic        mirror;
  logic        busy, done, fb_we;
  logic [18:0] src_read_address, fb_write_address;
  logic [23:0] src_data, fb_data_In;
`ifdef FB_BLITTER_SOLID_FILL_EN
  logic        fill;
  logic [23:0] fill_color;
`endif

  int compared   = 0;
  int mismatched = 0;
  int keyAddr    = -1;

  int wA[64];
  int wD[64];
  int wC[64];
  int nW;
  int rdAddr[64];
  int doneCyc;
  int doneCount;
  logic [63:0] busyMask;
  int weSeen, doneSeen, busySeen;

  fb_blitter dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .start           (start),
    .src_x           (src_x),
    .src_y           (src_y),
    .dst_x           (dst_x),
    .dst_y           (dst_y),
    .blit_w          (blit_w),
    .blit_h          (blit_h),
    .mirror          (mirror),
`ifdef FB_BLITTER_SOLID_FILL_EN
    .fill            (fill),
    .fill_color      (fill_color),
`endif
    .busy            (busy),
    .done            (done),
    .src_read_address(src_read_address),
    .src_data        (src_data),
    .fb_write_address(fb_write_address),
    .fb_data_In      (fb_data_In),
    .fb_we           (fb_we)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] srcModel(input int addr);
    if (addr == keyAddr) return KEY_COLOR;
    return 24'(addr);
  endfunction

  always @(posedge Clk) src_data <= srcModel(int'(src_read_address));

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one blit at cycle 0 and log cycles 1.. until a few cycles past done (bounded).
  task automatic applyStimulus(input int sx, input int sy, input int dx, input int dy,
                               input int w, input int h, input logic m, input int injectCyc);
    nW = 0; doneCyc = -1; doneCount = 0; busyMask = '0;
    @(negedge Clk);
    src_x = 9'(sx); src_y = 9'(sy); dst_x = 9'(dx); dst_y = 9'(dy);
    blit_w = 6'(w); blit_h = 6'(h); mirror = m; start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    for (int c = 1; c < 64; c++) begin
      @(negedge Clk);
      rdAddr[c] = int'(src_read_address);
      if (busy) busyMask[c] = 1'b1;
      if (fb_we && nW < 64) begin
        wA[nW] = int'(fb_write_address);
        wD[nW] = int'(fb_data_In);
        wC[nW] = c;
        nW++;
      end
      if (done) begin
        doneCount++;
        if (doneCyc < 0) doneCyc = c;
      end
      if (c == injectCyc) start = 1'b1;
      @(posedge Clk);
      #1 start = 1'b0;
      if (doneCyc > 0 && c >= doneCyc + 6) break;
    end
  endtask

  task automatic idleWatch(input int n);
    weSeen = 0; doneSeen = 0; busySeen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (fb_we) weSeen++;
      if (done)  doneSeen++;
      if (busy)  busySeen++;
    end
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; mirror = 1'b0;
    src_x = '0; src_y = '0; dst_x = '0; dst_y = '0; blit_w = '0; blit_h = '0;
`ifdef FB_BLITTER_SOLID_FILL_EN
    fill = 1'b0; fill_color = '0;
`endif
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checkOutput("rst_busy",  64'(busy), 0);
    checkOutput("rst_done",  64'(done), 0);
    checkOutput("rst_we",    64'(fb_we), 0);
    checkOutput("rst_raddr", 64'(src_read_address), 0);
    checkOutput("rst_waddr", 64'(fb_write_address), 0);
    checkOutput("rst_wdata", 64'(fb_data_In), 0);
    Reset = 1'b0;

    $display("[TB] 4x2 copy");
    applyStimulus(16, 0, 10, 20, 4, 2, 1'b0, 0);
    checkOutput("copy_nw", 64'(nW), 8);
    for (int i = 0; i < 4; i++) begin
      checkOutput("copy_a0", 64'(wA[i]), 64'(4810 + i));
      checkOutput("copy_a1", 64'(wA[i+4]), 64'(5050 + i));
      checkOutput("copy_d0", 64'(wD[i]), 64'(16 + i));
      checkOutput("copy_d1", 64'(wD[i+4]), 64'(287 + i));
    end
    checkOutput("copy_first_cyc", 64'(wC[0]), 2);
    checkOutput("copy_last_cyc",  64'(wC[7]), 9);
    checkOutput("copy_done_cyc",  64'(doneCyc), 10);
    checkOutput("copy_done_cnt",  64'(doneCount), 1);
    checkOutput("copy_busy",      busyMask, 64'h3FE);

    $display("[TB] mirrored 16x1");
    applyStimulus(31, 0, 100, 50, 16, 1, 1'b1, 0);
    checkOutput("mir_rd_first", 64'(rdAddr[1]), 46);
    checkOutput("mir_rd_last",  64'(rdAddr[16]), 31);
    checkOutput("mir_nw",       64'(nW), 16);
    for (int i = 0; i < 16; i++) begin
      checkOutput("mir_data", 64'(wD[i]), 64'(46 - i));
      checkOutput("mir_addr", 64'(wA[i]), 64'(12100 + i));
    end
    checkOutput("mir_done_cyc", 64'(doneCyc), 18);

    $display("[TB] key colour skip");
    keyAddr = 815;
    applyStimulus(0, 3, 0, 0, 5, 1, 1'b0, 0);
    keyAddr = -1;
    checkOutput("key_nw",      64'(nW), 4);
    checkOutput("key_a1",      64'(wA[1]), 1);
    checkOutput("key_a2",      64'(wA[2]), 3);
    checkOutput("key_c1",      64'(wC[1]), 3);
    checkOutput("key_c2",      64'(wC[2]), 5);
    checkOutput("key_d2",      64'(wD[2]), 816);
    checkOutput("key_done",    64'(doneCyc), 7);

    $display("[TB] right-edge clip");
    applyStimulus(0, 0, 236, 10, 8, 1, 1'b0, 0);
    checkOutput("clip_nw",    64'(nW), 4);
    checkOutput("clip_a0",    64'(wA[0]), 2636);
    checkOutput("clip_a3",    64'(wA[3]), 2639);
    checkOutput("clip_c3",    64'(wC[3]), 5);
    checkOutput("clip_done",  64'(doneCyc), 10);
    checkOutput("clip_busy",  busyMask, 64'h3FE);

    $display("[TB] zero width");
    applyStimulus(0, 0, 0, 0, 0, 5, 1'b0, 0);
    checkOutput("zero_done", 64'(doneCyc), 1);
    checkOutput("zero_nw",   64'(nW), 0);
    checkOutput("zero_busy", busyMask, 0);
    checkOutput("zero_cnt",  64'(doneCount), 1);

    $display("[TB] start while busy");
    applyStimulus(0, 0, 0, 0, 4, 1, 1'b0, 3);
    checkOutput("inj_done",  64'(doneCyc), 6);
    checkOutput("inj_cnt",   64'(doneCount), 1);
    checkOutput("inj_nw",    64'(nW), 4);
    checkOutput("inj_busy",  busyMask, 64'h3E);

    $display("[TB] reset mid-blit");
    @(negedge Clk);
    src_x = '0; src_y = '0; dst_x = '0; dst_y = '0;
    blit_w = 6'd16; blit_h = 6'd1; mirror = 1'b0; start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    repeat (5) @(negedge Clk);
    checkOutput("rstmid_pre_we",   64'(fb_we), 1);
    checkOutput("rstmid_pre_addr", 64'(fb_write_address), 3);
    Reset = 1'b1;
    #1;
    checkOutput("rstmid_we",   64'(fb_we), 0);
    checkOutput("rstmid_busy", 64'(busy), 0);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    idleWatch(25);
    checkOutput("rstmid_no_done", 64'(doneSeen), 0);
    checkOutput("rstmid_no_we",   64'(weSeen), 0);
    checkOutput("rstmid_no_busy", 64'(busySeen), 0);
    applyStimulus(16, 0, 10, 20, 4, 2, 1'b0, 0);
    checkOutput("after_rst_done", 64'(doneCyc), 10);
    checkOutput("after_rst_nw",   64'(nW), 8);
    checkOutput("after_rst_a0",   64'(wA[0]), 4810);

`ifdef FB_BLITTER_SOLID_FILL_EN
    $display("[TB] solid fill 3x3");
    keyAddr = 0;
    fill = 1'b1; fill_color = 24'hE8E088;
    applyStimulus(2, 2, 5, 5, 3, 3, 1'b0, 0);
    fill = 1'b0; keyAddr = -1;
    checkOutput("fill_nw",   64'(nW), 9);
    checkOutput("fill_rd",   64'(rdAddr[1]), 0);
    for (int i = 0; i < 9; i++) begin
      checkOutput("fill_data", 64'(wD[i]), 64'h E8E088);
      checkOutput("fill_addr", 64'(wA[i]), 64'(1205 + (i / 3) * 240 + (i % 3)));
    end
    checkOutput("fill_done", 64'(doneCyc), 11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
